mips_phase_sequencer: RTL and testbench
=======================================

# mips_phase_sequencer

Multi-cycle phase generator for the MIPS CPU: drives the one-hot phase strobes P0–P4 and the instruction-complete strobe P that the per-instruction control models consume. It samples the decoded opcode and function fields during the decode phase, picks the phase count for the instruction class, and emits the ALU function code Func. It counts retired instructions and flags unsupported opcodes.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `run`  in  1  enables instruction issue; sampled only at instruction boundaries.
- `Op`  in  6  opcode field from IR; valid while P1 is high.
- `IRFunc`  in  6  funct field from IR; valid while P1 is high.
- `P0`..`P4`  out  1 each  phase strobes: fetch, decode, execute, memory, writeback.
- `P`  out  1  high during the final phase cycle of every instruction.
- `Func`  out  6  ALU function code for the current instruction.
- `illegal`  out  1  high together with P when the opcode is unsupported.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: IDLE, PH0, PH1, PH2, PH3, PH4. Px is high exactly when the state is PHx. At most one of P0–P4 is high; all are low in IDLE.
- IDLE goes to PH0 when run=1; otherwise it stays in IDLE.
- PH0 goes to PH1 unconditionally.
- In PH1, classify the live Op/IRFunc and latch the class, Op and IRFunc.
- Phase sequences and Func per class:
  - R-type, Op=000000: P0 P1 P2 P3; Func=IRFunc.
  - lw, Op=100011: P0 P1 P2 P3 P4; Func=100000.
  - sw, Op=101011: P0 P1 P2 P3; Func=100000.
  - addi, Op=001000: P0 P1 P2 P3; Func=100000.
  - beq, Op=000100: P0 P1 P2; Func=100010.
  - j, Op=000010: P0 P1 P2; Func=000000.
  - Any other opcode: P0 P1 P2; Func=000000; illegal=1 in P2.
- The final phase of each sequence asserts P.
- After the final phase: go to PH0 if run=1 in that cycle, else to IDLE. There are no idle gaps between back-to-back instructions.
- run is ignored mid-instruction. Deasserting run never truncates an instruction.
- `retired` increments by 1 on every cycle with P=1 and wraps from all-ones to 0. Illegal instructions also count.
- A clr in any state forces the reset values on the next edge. The current instruction is abandoned and is not counted.

## Timing
- Reset values: state IDLE, P0–P4=0, P=0, illegal=0, Func=000000, retired=0.
- Issue latency: run sampled high in IDLE at edge N → P0 high in cycle N+1.
- Func is registered and updated at the PH1→PH2 edge. It is valid from P2 to the end of the instruction and holds its value until the next PH1→PH2 edge.
- Op/IRFunc are don't-care outside P1.
- P and illegal are combinational from the state and the latched class; they do not depend on live inputs.
- Instruction length in cycles: R/sw/addi = 4, lw = 5, beq/j/illegal = 3.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J;
  - ALU funct constants: FN_ADD=100000, FN_SUB=100010;
  - the phase-state enum and the instruction-class enum.
- One sub-module, `mips_op_classify`: purely combinational; Op, IRFunc → class, Func, illegal. It is instantiated once, and its outputs are registered in PH1.
- The top level holds the state register, the class/Func registers and the counter.

## Test plan
- Reset, then run=1 with Op=000000, IRFunc=100000 held: P0,P1,P2,P3 in cycles 1–4; P in cycle 4; Func=100000 from cycle 3; next P0 in cycle 5; retired=1 after cycle 4.
- lw (100011) then beq (000100) back-to-back: phases P0–P4 then P0–P2; P pulses 5 cycles apart, then 3 cycles later; Func=100000 then 100010; retired=2.
- Op=111111: P0 P1 P2 with P=1 and illegal=1 in P2; Func=000000; retired increments.
- run dropped during P2 of an R-type: P3 still occurs with P=1, then IDLE. Reasserting run gives P0 on the next cycle.
- clr asserted in P3 of lw: next cycle all outputs are at reset values and retired is unchanged at 0.
- Preload via 65535 instructions (or CNT_W=4 with 15): one more instruction wraps retired to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS multi-cycle phase sequencer.
//   - opcode constants for the supported instruction classes
//   - ALU funct constants
//   - phase-state enum and instruction-class enum
//   - last_phase(): final phase of the sequence for a given class
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_NONE  = 6'b000000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH0  = 3'd1,
        PH1  = 3'd2,
        PH2  = 3'd3,
        PH3  = 3'd4,
        PH4  = 3'd5
    } phase_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_ADDI = 3'd3,
        CLS_BEQ  = 3'd4,
        CLS_J    = 3'd5,
        CLS_ILL  = 3'd6
    } iclass_t;

    // Final phase of each class: lw needs writeback (PH4); R/sw/addi end in
    // PH3; branches, jumps and unsupported opcodes finish in execute (PH2).
    function automatic phase_t last_phase(iclass_t c);
        case (c)
            CLS_LW:                    return PH4;
            CLS_R, CLS_SW, CLS_ADDI:   return PH3;
            default:                   return PH2;
        endcase
    endfunction

endpackage

// File: rtl/mips_phase_sequencer_if.sv
// mips_phase_sequencer_if: bundle between the phase sequencer and its
// surrounding control/datapath.
//   run            : issue enable (control -> sequencer)
//   Op, IRFunc     : IR opcode/funct fields (control -> sequencer)
//   P0..P4, P      : phase strobes and instruction-complete strobe
//   Func           : registered ALU function code
//   illegal        : unsupported opcode, asserted with P
//   retired        : completed-instruction counter
//   state          : current FSM state, exported for observation
//
// Handshake: run is a level enable, not a valid/ready pair. The sequencer
// samples it only in IDLE and in the final phase cycle (P=1); a high sample
// starts the next instruction (P0) on the following cycle. Op/IRFunc must be
// stable during P1 and are ignored at all other times.
interface mips_phase_sequencer_if #(
    parameter int CNT_W = 16
);
    import mips_pkg::*;

    logic             run;
    logic [5:0]       Op;
    logic [5:0]       IRFunc;
    logic             P0;
    logic             P1;
    logic             P2;
    logic             P3;
    logic             P4;
    logic             P;
    logic [5:0]       Func;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    phase_t           state;

    modport master (
        output run, Op, IRFunc,
        input  P0, P1, P2, P3, P4, P, Func, illegal, retired, state
    );

    modport slave (
        input  run, Op, IRFunc,
        output P0, P1, P2, P3, P4, P, Func, illegal, retired, state
    );

endinterface

// File: rtl/mips_op_classify.sv
// mips_op_classify: combinational opcode decoder.
//   op, irfunc : IR opcode and funct fields
//   cls        : instruction class
//   func       : ALU function code for the class (funct for R-type)
//   illegal    : opcode not in the supported set
module mips_op_classify
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] irfunc,
    output iclass_t    cls,
    output logic [5:0] func,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_ILL;
        func    = FN_NONE;
        illegal = 1'b1;
        case (op)
            OP_RTYPE: begin cls = CLS_R;    func = irfunc;  illegal = 1'b0; end
            OP_LW:    begin cls = CLS_LW;   func = FN_ADD;  illegal = 1'b0; end
            OP_SW:    begin cls = CLS_SW;   func = FN_ADD;  illegal = 1'b0; end
            OP_ADDI:  begin cls = CLS_ADDI; func = FN_ADD;  illegal = 1'b0; end
            OP_BEQ:   begin cls = CLS_BEQ;  func = FN_SUB;  illegal = 1'b0; end
            OP_J:     begin cls = CLS_J;    func = FN_NONE; illegal = 1'b0; end
            default:  begin cls = CLS_ILL;  func = FN_NONE; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/mips_phase_sequencer.sv
// mips_phase_sequencer: multi-cycle phase generator for the MIPS CPU.
//   clk  : clock, rising edge
//   clr  : synchronous active-high reset
//   bus  : mips_phase_sequencer_if.slave (run/Op/IRFunc in; phase strobes,
//          P, Func, illegal, retired and state out)
// The opcode is classified during PH1 and the class/Func are latched on the
// PH1->PH2 edge; the class then selects which phase ends the instruction.
module mips_phase_sequencer
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        clr,
    mips_phase_sequencer_if.slave       bus
);

    phase_t           state;
    phase_t           state_nxt;
    iclass_t          cls_q;
    logic             ill_q;
    logic [5:0]       func_q;
    logic [CNT_W-1:0] cnt_q;

    iclass_t          dec_cls;
    logic [5:0]       dec_func;
    logic             dec_ill;
    logic             p_last;

    mips_op_classify u_classify (
        .op      (bus.Op),
        .irfunc  (bus.IRFunc),
        .cls     (dec_cls),
        .func    (dec_func),
        .illegal (dec_ill)
    );

    // last_phase() never returns PH0/PH1, so a stale class from the previous
    // instruction cannot raise P before the new class is latched.
    assign p_last = (state != IDLE) && (state == last_phase(cls_q));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.run) state_nxt = PH0;
            PH0:     state_nxt = PH1;
            PH1:     state_nxt = PH2;
            PH2:     state_nxt = p_last ? (bus.run ? PH0 : IDLE) : PH3;
            PH3:     state_nxt = p_last ? (bus.run ? PH0 : IDLE) : PH4;
            PH4:     state_nxt = bus.run ? PH0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            cls_q  <= CLS_J;
            ill_q  <= 1'b0;
            func_q <= FN_NONE;
            cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == PH1) begin
                cls_q  <= dec_cls;
                ill_q  <= dec_ill;
                func_q <= dec_func;
            end
            if (p_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.P0      = (state == PH0);
    assign bus.P1      = (state == PH1);
    assign bus.P2      = (state == PH2);
    assign bus.P3      = (state == PH3);
    assign bus.P4      = (state == PH4);
    assign bus.P       = p_last;
    assign bus.illegal = p_last & ill_q;
    assign bus.Func    = func_q;
    assign bus.retired = cnt_q;
    assign bus.state   = state;

endmodule

// File: tb/tb_mips_phase_sequencer.sv
// tb_mips_phase_sequencer: directed stimulus with a scoreboard queue; a
// monitor pops one expectation for every P pulse and checks the per-cycle
// phase sequence, Func, illegal and the retired count.
module tb_mips_phase_sequencer;
    import mips_pkg::*;

    localparam int CW = 4;

    typedef struct {
        int          len;
        logic [5:0]  func;
        logic        ill;
        logic [CW-1:0] ret;
    } exp_t;

    logic clk;
    logic clr;
    int   cyc;
    int   n_chk;
    int   n_err;
    bit   mon_en;
    exp_t exp_q[$];
    logic [CW-1:0] model_ret;

    mips_phase_sequencer_if #(.CNT_W(CW)) bus ();

    mips_phase_sequencer #(.CNT_W(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // clock / cycle counter / global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: act=running req=finished");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: act=%0d req=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int ph_idx();
        if (bus.P0) return 0;
        if (bus.P1) return 1;
        if (bus.P2) return 2;
        if (bus.P3) return 3;
        if (bus.P4) return 4;
        return -1;
    endfunction

    // driver: wait for P0, present the instruction through P1, then scramble
    // the IR fields (don't-care) and optionally drop run in P2.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input int len, input logic [5:0] efunc, input logic eill,
                         input bit keep_run, output int waited);
        exp_t e;
        bit   found;
        found  = 0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (bus.P0) begin
                found = 1;
                break;
            end
        end
        chk("issue_p0_seen", int'(found), 1);
        e.len  = len;
        e.func = efunc;
        e.ill  = eill;
        e.ret  = model_ret;
        exp_q.push_back(e);
        model_ret  = model_ret + 1'b1;
        bus.Op     = op;
        bus.IRFunc = fn;
        @(negedge clk);
        @(negedge clk);
        bus.Op     = 6'($urandom_range(0, 63));
        bus.IRFunc = 6'($urandom_range(0, 63));
        if (!keep_run) bus.run = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin
        int  idx;
        int  start_cyc;
        bit  active;
        bit  prev_p;
        exp_t e;
        active    = 0;
        prev_p    = 0;
        start_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (clr || !mon_en) begin
                active = 0;
                prev_p = 0;
            end else begin
                idx = ph_idx();
                chk("onehot", int'($countones({bus.P4, bus.P3, bus.P2, bus.P1, bus.P0}) <= 1), 1);
                if (prev_p) chk("boundary_next", idx, bus.run ? 0 : -1);
                if (bus.P0) begin
                    start_cyc = cyc;
                    active    = 1;
                end
                if (active) chk("phase_seq", idx, cyc - start_cyc);
                else        chk("idle_phase", idx, -1);
                if (active && idx >= 2 && exp_q.size() > 0)
                    chk("func", int'(bus.Func), int'(exp_q[0].func));
                if (bus.P) begin
                    if (exp_q.size() == 0) begin
                        chk("p_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_len", cyc - start_cyc + 1, e.len);
                        chk("illegal", int'(bus.illegal), int'(e.ill));
                        chk("retired_at_p", int'(bus.retired), int'(e.ret));
                    end
                    active = 0;
                end else begin
                    chk("illegal_low", int'(bus.illegal), 0);
                end
                prev_p = bus.P;
            end
        end
    end

    // directed sequence
    initial begin
        int w;
        bit drained;
        n_chk      = 0;
        n_err      = 0;
        mon_en     = 0;
        model_ret  = '0;
        clr        = 1'b1;
        bus.run    = 1'b0;
        bus.Op     = 6'd0;
        bus.IRFunc = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst_phases", int'({bus.P4, bus.P3, bus.P2, bus.P1, bus.P0}), 0);
        chk("rst_p", int'(bus.P), 0);
        chk("rst_illegal", int'(bus.illegal), 0);
        chk("rst_func", int'(bus.Func), 0);
        chk("rst_retired", int'(bus.retired), 0);
        chk("rst_state", int'(bus.state), int'(IDLE));
        clr    = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("idle_hold", int'(bus.state), int'(IDLE));

        // clr in P3 of lw: instruction abandoned, not counted
        bus.run = 1'b1;
        issue(OP_LW, 6'd0, 5, FN_ADD, 1'b0, 1'b1, w);
        @(negedge clk);
        chk("clr_pre_p3", int'(bus.P3), 1);
        clr     = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);
        chk("clr_phases", int'({bus.P4, bus.P3, bus.P2, bus.P1, bus.P0}), 0);
        chk("clr_p", int'(bus.P), 0);
        chk("clr_func", int'(bus.Func), 0);
        chk("clr_retired", int'(bus.retired), 0);
        chk("clr_state", int'(bus.state), int'(IDLE));
        exp_q.delete();
        model_ret = '0;
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // R-type add, then lw/beq back-to-back, then an illegal opcode
        bus.run = 1'b1;
        issue(OP_RTYPE, 6'b100000, 4, 6'b100000, 1'b0, 1'b1, w);
        chk("issue_latency_r", w, 1);
        issue(OP_LW,  6'd7,  5, FN_ADD, 1'b0, 1'b1, w);
        issue(OP_BEQ, 6'd9,  3, FN_SUB, 1'b0, 1'b1, w);
        issue(6'b111111, 6'b100010, 3, 6'b000000, 1'b1, 1'b1, w);

        // run dropped during P2 of an R-type: P3 still completes, then IDLE
        issue(OP_RTYPE, 6'b100101, 4, 6'b100101, 1'b0, 1'b0, w);
        repeat (3) @(negedge clk);
        chk("drop_idle", int'(bus.state), int'(IDLE));
        chk("drop_retired", int'(bus.retired), 5);
        bus.run = 1'b1;
        issue(OP_J,    6'd0, 3, 6'b000000, 1'b0, 1'b1, w);
        chk("issue_latency_j", w, 1);
        issue(OP_SW,   6'd3, 4, FN_ADD, 1'b0, 1'b1, w);
        issue(OP_ADDI, 6'd5, 4, FN_ADD, 1'b0, 1'b1, w);

        // 8 more instructions take the 4-bit counter from 8 through 15 to 0
        for (int i = 0; i < 8; i++) begin
            issue(OP_J, 6'($urandom_range(0, 63)), 3, 6'b000000, 1'b0, (i != 7), w);
        end
        drained = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.state == IDLE) begin
                drained = 1;
                break;
            end
        end
        chk("drain", int'(drained), 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("wrap_retired", int'(bus.retired), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
